gnr_attractor_ctrl: RTL and testbench

Sweep controller that drives a bank of N_NODES Boolean network nodes. Each node holds a slow trajectory s0 and a fast trajectory s1. The controller loads each initial state, steps the network with Floyd cycle detection, then measures the attractor period. It feeds reset_nos, init_state, start_s0 and start_s1 to the node bank, consumes the concatenated s0/s1 vectors, and emits one result record per initial state over a valid/ready handshake.

---
 rtl/gnr_attractor_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnr_attractor_ctrl.sv
// Sweep controller for a Boolean-network node bank: per initial state, Floyd cycle
// detection followed by period measurement. Optional GNR_SWEEP_STATS_EN adds result counters.
module gnr_attractor_ctrl #(
    parameter int unsigned N_NODES   = 188,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STEPS = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_first,
    input  logic [CNT_W-1:0]   init_count,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_transient,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic               busy,
`ifdef GNR_SWEEP_STATS_EN
    output logic [CNT_W-1:0]   stat_found,
    output logic [CNT_W-1:0]   stat_timeout,
`endif
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STEP, S_CHECK, S_PSTEP, S_PCHECK, S_REPORT, S_NEXT
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    state_t             state_q;
    logic [N_NODES-1:0] cur_init_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [CNT_W-1:0]   k_q;
    logic [CNT_W-1:0]   per_q;
    logic               reset_nos_q;
    logic [N_NODES-1:0] init_state_q;
    logic               start_s0_q;
    logic               start_s1_q;
    logic               res_valid_q;
    logic [N_NODES-1:0] res_init_q;
    logic [CNT_W-1:0]   res_transient_q;
    logic [CNT_W-1:0]   res_period_q;
    logic               res_timeout_q;
    logic               done_q;

    logic vec_eq;
    assign vec_eq = (s0_vec == s1_vec);

    // Outputs are registered one state ahead so each pulse is high exactly
    // during the state that owns it (reset_nos in LOAD, done in NEXT, ...).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cur_init_q      <= '0;
            remaining_q     <= '0;
            k_q             <= '0;
            per_q           <= '0;
            reset_nos_q     <= 1'b0;
            init_state_q    <= '0;
            start_s0_q      <= 1'b0;
            start_s1_q      <= 1'b0;
            res_valid_q     <= 1'b0;
            res_init_q      <= '0;
            res_transient_q <= '0;
            res_period_q    <= '0;
            res_timeout_q   <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_init_q  <= init_first;
                        remaining_q <= init_count;
                        if (init_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= S_LOAD;
                            reset_nos_q  <= 1'b1;
                            init_state_q <= init_first;
                        end
                    end
                end
                S_LOAD: begin
                    reset_nos_q     <= 1'b0;
                    k_q             <= '0;
                    per_q           <= '0;
                    res_init_q      <= cur_init_q;
                    res_transient_q <= '0;
                    res_period_q    <= '0;
                    res_timeout_q   <= 1'b0;
                    start_s0_q      <= 1'b1;
                    start_s1_q      <= 1'b1;
                    state_q         <= S_STEP;
                end
                S_STEP: begin
                    start_s0_q <= 1'b0;
                    start_s1_q <= 1'b0;
                    k_q        <= k_q + CNT_W'(1);
                    state_q    <= S_CHECK;
                end
                S_CHECK: begin
                    // k==1 always matches (both trajectories took one step), so skip it
                    if (k_q >= CNT_W'(2) && vec_eq) begin
                        res_transient_q <= k_q;
                        start_s1_q      <= 1'b1;
                        state_q         <= S_PSTEP;
                    end else if (k_q == MAX_CNT) begin
                        res_timeout_q <= 1'b1;
                        res_period_q  <= '0;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_REPORT;
                    end else begin
                        start_s0_q <= 1'b1;
                        start_s1_q <= 1'b1;
                        state_q    <= S_STEP;
                    end
                end
                S_PSTEP: begin
                    start_s1_q <= 1'b0;
                    per_q      <= per_q + CNT_W'(1);
                    state_q    <= S_PCHECK;
                end
                S_PCHECK: begin
                    if (vec_eq) begin
                        res_period_q <= per_q;
                        res_valid_q  <= 1'b1;
                        state_q      <= S_REPORT;
                    end else if (per_q == MAX_CNT) begin
                        res_timeout_q <= 1'b1;
                        res_period_q  <= '0;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_REPORT;
                    end else begin
                        start_s1_q <= 1'b1;
                        state_q    <= S_PSTEP;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_NEXT;
                        if (remaining_q == CNT_W'(1)) done_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    remaining_q <= remaining_q - CNT_W'(1);
                    cur_init_q  <= cur_init_q + N_NODES'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q      <= S_LOAD;
                        reset_nos_q  <= 1'b1;
                        init_state_q <= cur_init_q + N_NODES'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef GNR_SWEEP_STATS_EN
    logic [CNT_W-1:0] stat_found_q;
    logic [CNT_W-1:0] stat_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_found_q   <= '0;
            stat_timeout_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stat_found_q   <= '0;
            stat_timeout_q <= '0;
        end else if (state_q == S_REPORT && res_ready) begin
            if (!res_timeout_q) begin
                if (stat_found_q != '1) stat_found_q <= stat_found_q + CNT_W'(1);
            end else begin
                if (stat_timeout_q != '1) stat_timeout_q <= stat_timeout_q + CNT_W'(1);
            end
        end
    end

    assign stat_found   = stat_found_q;
    assign stat_timeout = stat_timeout_q;
`endif

    assign reset_nos     = reset_nos_q;
    assign init_state    = init_state_q;
    assign start_s0      = start_s0_q;
    assign start_s1      = start_s1_q;
    assign res_valid     = res_valid_q;
    assign res_init      = res_init_q;
    assign res_transient = res_transient_q;
    assign res_period    = res_period_q;
    assign res_timeout   = res_timeout_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: two instances (step limit 64 and 4), each driving
// a 4-node rotate-left network model; results checked against tables and a reference model.
module tb_gnr_attractor_ctrl;

    typedef struct packed {
        logic [3:0]  init;
        logic [15:0] trans;
        logic [15:0] per;
        logic        to;
    } rec_t;

    typedef struct {
        logic [3:0] init;
        int         trans;
        int         per;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [3:0]  init_first = '0;
    logic [15:0] init_count = '0;
    logic        res_ready = 1'b0;

    logic        reset_nos_a, start_s0_a, start_s1_a, res_valid_a, res_timeout_a, busy_a, done_a;
    logic [3:0]  init_state_a, res_init_a;
    logic [15:0] res_transient_a, res_period_a;
    logic        reset_nos_b, start_s0_b, start_s1_b, res_valid_b, res_timeout_b, busy_b, done_b;
    logic [3:0]  init_state_b, res_init_b;
    logic [15:0] res_transient_b, res_period_b;

    logic [3:0] s0_a = '0, s1_a = '0, s0_b = '0, s1_b = '0;
    logic       ph_a = 1'b0, ph_b = 1'b0;

    gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(64)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .init_first(init_first), .init_count(init_count),
        .s0_vec(s0_a), .s1_vec(s1_a), .reset_nos(reset_nos_a), .init_state(init_state_a),
        .start_s0(start_s0_a), .start_s1(start_s1_a), .res_valid(res_valid_a), .res_ready(res_ready),
        .res_init(res_init_a), .res_transient(res_transient_a), .res_period(res_period_a),
        .res_timeout(res_timeout_a), .busy(busy_a), .done(done_a)
    );

    gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .init_first(init_first), .init_count(init_count),
        .s0_vec(s0_b), .s1_vec(s1_b), .reset_nos(reset_nos_b), .init_state(init_state_b),
        .start_s0(start_s0_b), .start_s1(start_s1_b), .res_valid(res_valid_b), .res_ready(res_ready),
        .res_init(res_init_b), .res_transient(res_transient_b), .res_period(res_period_b),
        .res_timeout(res_timeout_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [3:0] rotl(input logic [3:0] x, input int n);
        logic [3:0] r;
        r = x;
        for (int i = 0; i < n % 4; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    // Node bank: s0 moves on every other start_s0 (first one after load), s1 on every start_s1.
    always @(posedge clk) begin
        if (reset_nos_a) begin
            s0_a <= init_state_a; s1_a <= init_state_a; ph_a <= 1'b0;
        end else begin
            if (start_s0_a) begin
                if (!ph_a) s0_a <= rotl(s0_a, 1);
                ph_a <= ~ph_a;
            end
            if (start_s1_a) s1_a <= rotl(s1_a, 1);
        end
        if (reset_nos_b) begin
            s0_b <= init_state_b; s1_b <= init_state_b; ph_b <= 1'b0;
        end else begin
            if (start_s0_b) begin
                if (!ph_b) s0_b <= rotl(s0_b, 1);
                ph_b <= ~ph_b;
            end
            if (start_s1_b) s1_b <= rotl(s1_b, 1);
        end
    end

    // Reference: x_k = init rotated k; first k>=2 with x_k == x_ceil(k/2), then smallest p.
    function automatic rec_t model(input logic [3:0] init, input int maxs);
        rec_t r;
        bit   found;
        r = '{init: init, trans: 16'd0, per: 16'd0, to: 1'b1};
        found = 0;
        for (int k = 2; k <= maxs && !found; k++) begin
            if (rotl(init, k) == rotl(init, (k + 1) / 2)) begin
                found = 1;
                r.trans = 16'(k);
                for (int p = 1; p <= maxs && r.to; p++) begin
                    if (rotl(init, k + p) == rotl(init, (k + 1) / 2)) begin
                        r.per = 16'(p);
                        r.to  = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    int tests = 0;
    int failed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor
    rec_t got_a[$];
    rec_t got_b[$];
    int   cyc = 0, hs_cyc_a = 0, done_cyc_a = 0;
    int   done_cnt_a = 0, done_cnt_b = 0, rn_cnt_a = 0, vld_cnt_a = 0, step_b = 0;
    int   ovl_err = 0, stab_err = 0;
    bit   prev_stall_a = 0;
    rec_t prev_a, cur_a;

    always @(negedge clk) begin
        cyc++;
        cur_a = '{init: res_init_a, trans: res_transient_a, per: res_period_a, to: res_timeout_a};
        if (prev_stall_a && (!res_valid_a || cur_a != prev_a)) stab_err++;
        prev_stall_a = res_valid_a && !res_ready;
        prev_a = cur_a;
        if (res_valid_a && res_ready) begin got_a.push_back(cur_a); hs_cyc_a = cyc; end
        if (res_valid_b && res_ready)
            got_b.push_back('{init: res_init_b, trans: res_transient_b, per: res_period_b, to: res_timeout_b});
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
        if (done_b) done_cnt_b++;
        if (reset_nos_a) rn_cnt_a++;
        if (res_valid_a) vld_cnt_a++;
        if (start_s0_b) step_b++;
        if (reset_nos_a && (start_s0_a || start_s1_a)) ovl_err++;
        if (reset_nos_b && (start_s0_b || start_s1_b)) ovl_err++;
    end

    // res_ready: 0 always high, 1 low for 10 cycles of each record, 2 random
    int rmode = 0;
    int stallc = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: res_ready = 1'b1;
            1: begin
                if (!res_valid_a) begin stallc = 0; res_ready = 1'b0; end
                else begin stallc++; res_ready = (stallc > 10); end
            end
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_start(input bit which, input logic [3:0] init, input logic [15:0] cnt);
        @(posedge clk); #1;
        init_first = init; init_count = cnt;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_done(input bit which, output bit ok);
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            if ((which ? done_b : done_a) === 1'b1) ok = 1;
            else begin @(negedge clk); #1; end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs_a();
        return 64'({reset_nos_a, init_state_a, start_s0_a, start_s1_a, res_valid_a, res_init_a,
                    res_transient_a, res_period_a, res_timeout_a, busy_a, done_a});
    endfunction

    vec_t tbl[6];
    bit   ok;
    int   d0, r0, v0;
    rec_t e;

    initial begin
        tbl[0] = '{4'b0001, 8, 4};
        tbl[1] = '{4'b0000, 2, 1};
        tbl[2] = '{4'b1111, 2, 1};
        tbl[3] = '{4'b0101, 4, 2};
        tbl[4] = '{4'b0011, 8, 4};
        tbl[5] = '{4'b1010, 4, 2};

        repeat (3) @(negedge clk);
        chk("reset_outputs_a", outs_a(), 64'd0);
        chk("reset_busy_b", 64'(busy_b), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Single-record table
        for (int i = 0; i < 6; i++) begin
            got_a.delete();
            d0 = done_cnt_a;
            pulse_start(0, tbl[i].init, 16'd1);
            wait_done(0, ok);
            chk($sformatf("tbl%0d_done", i), 64'(ok), 64'd1);
            chk($sformatf("tbl%0d_nrec", i), 64'(got_a.size()), 64'd1);
            if (got_a.size() == 1) begin
                chk($sformatf("tbl%0d_rec", i), 64'(got_a[0]),
                    64'(rec_t'{init: tbl[i].init, trans: 16'(tbl[i].trans), per: 16'(tbl[i].per), to: 1'b0}));
            end
            chk($sformatf("tbl%0d_done_cnt", i), 64'(done_cnt_a - d0), 64'd1);
            if (i == 0) chk("done_after_hs", 64'(done_cyc_a - hs_cyc_a), 64'd1);
            chk($sformatf("tbl%0d_idle", i), 64'(busy_a), 64'd0);
        end

        // Step limit: timeout, and a match landing exactly on the limit
        got_b.delete(); step_b = 0;
        pulse_start(1, 4'b0001, 16'd1);
        wait_done(1, ok);
        chk("to_done", 64'(ok), 64'd1);
        chk("to_nrec", 64'(got_b.size()), 64'd1);
        if (got_b.size() == 1)
            chk("to_rec", 64'(got_b[0]), 64'(rec_t'{init: 4'b0001, trans: 16'd0, per: 16'd0, to: 1'b1}));
        chk("to_steps", 64'(step_b), 64'd4);
        got_b.delete();
        pulse_start(1, 4'b0101, 16'd1);
        wait_done(1, ok);
        chk("lim_nrec", 64'(got_b.size()), 64'd1);
        if (got_b.size() == 1)
            chk("lim_rec", 64'(got_b[0]), 64'(rec_t'{init: 4'b0101, trans: 16'd4, per: 16'd2, to: 1'b0}));

        // Zero-length sweep
        got_a.delete(); d0 = done_cnt_a; r0 = rn_cnt_a; v0 = vld_cnt_a;
        pulse_start(0, 4'b0110, 16'd0);
        wait_done(0, ok);
        chk("zero_done", 64'(ok), 64'd1);
        chk("zero_done_cnt", 64'(done_cnt_a - d0), 64'd1);
        chk("zero_no_load", 64'(rn_cnt_a - r0), 64'd0);
        chk("zero_no_valid", 64'(vld_cnt_a - v0), 64'd0);

        // Backpressured sweep with wrap
        rmode = 1;
        got_a.delete(); d0 = done_cnt_a;
        pulse_start(0, 4'b1110, 16'd3);
        wait_done(0, ok);
        chk("bp_done", 64'(ok), 64'd1);
        chk("bp_nrec", 64'(got_a.size()), 64'd3);
        for (int j = 0; j < 3 && j < got_a.size(); j++) begin
            e = model(4'b1110 + 4'(j), 64);
            chk($sformatf("bp_rec%0d", j), 64'(got_a[j]), 64'(e));
        end
        chk("bp_init_last", 64'(got_a.size() == 3 ? got_a[2].init : 4'hx), 64'(4'b0000));
        chk("bp_done_cnt", 64'(done_cnt_a - d0), 64'd1);
        rmode = 0;

        // Start while busy is ignored
        got_a.delete(); d0 = done_cnt_a;
        pulse_start(0, 4'b0001, 16'd1);
        repeat (4) @(posedge clk);
        pulse_start(0, 4'b0000, 16'd3);
        wait_done(0, ok);
        repeat (40) @(negedge clk);
        #1;
        chk("busy_nrec", 64'(got_a.size()), 64'd1);
        if (got_a.size() == 1) chk("busy_rec_init", 64'(got_a[0].init), 64'(4'b0001));
        chk("busy_done_cnt", 64'(done_cnt_a - d0), 64'd1);
        chk("busy_idle", 64'(busy_a), 64'd0);

        // Start coincident with reset
        r0 = rn_cnt_a;
        @(posedge clk); #1; rst = 1'b1; start_a = 1'b1; init_count = 16'd1;
        @(posedge clk); #1; rst = 1'b0; start_a = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("rststart_busy", 64'(busy_a), 64'd0);
        chk("rststart_no_load", 64'(rn_cnt_a - r0), 64'd0);

        // Reset during period measurement
        got_a.delete(); d0 = done_cnt_a;
        pulse_start(0, 4'b0001, 16'd1);
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (start_s1_a && !start_s0_a) ok = 1;
        end
        chk("abort_saw_pstep", 64'(ok), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", outs_a(), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt_a - d0), 64'd0);
        chk("abort_no_rec", 64'(got_a.size()), 64'd0);
        chk("abort_idle", 64'(busy_a), 64'd0);

        // Randomized sweeps against the reference model
        rmode = 2;
        for (int it = 0; it < 15; it++) begin
            logic [3:0]  ri;
            logic [15:0] rc;
            ri = 4'($urandom_range(0, 15));
            rc = 16'($urandom_range(1, 3));
            got_a.delete(); d0 = done_cnt_a;
            pulse_start(0, ri, rc);
            wait_done(0, ok);
            chk($sformatf("rnd%0d_nrec", it), 64'(got_a.size()), 64'(rc));
            for (int j = 0; j < int'(rc) && j < got_a.size(); j++) begin
                e = model(ri + 4'(j), 64);
                chk($sformatf("rnd%0d_rec%0d", it, j), 64'(got_a[j]), 64'(e));
            end
            chk($sformatf("rnd%0d_done_cnt", it), 64'(done_cnt_a - d0), 64'd1);
        end
        rmode = 0;

        chk("no_load_step_overlap", 64'(ovl_err), 64'd0);
        chk("stall_stability", 64'(stab_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
